// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake bundle between two pipeline stages.
// The upstream side presents in_* and sees in_ready; the downstream side
// sees out_* and presents out_ready. The stage register itself is the
// slave; whatever drives it (a neighbouring stage or a bench) is the master.
`timescale 1ns/1ps

interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid,
        output in_data,
        output in_ctrl,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ctrl,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_ctrl,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ctrl,
        input  out_ready
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised handshaked pipeline stage register.
// Holds one entry (SKID=0) or a main entry plus one skid entry (SKID=1),
// keeps strict FIFO order, turns flushed/empty slots into bubbles whose
// control payload is zero, and counts output stall cycles (saturating).
`timescale 1ns/1ps

module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    pipe_stage_reg_if.slave   bus,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main register: this is what the downstream stage sees.
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

    // Skid register: only ever occupied when SKID=1 and main is stalled.
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              main_valid_nxt;
    logic [DATA_W-1:0] main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl_nxt;
    logic              skid_valid_nxt;
    logic [DATA_W-1:0] skid_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl_nxt;

    logic              in_fire;
    logic              out_fire;

    // With a skid slot, ready comes from a flop (only gated by flush), so
    // the downstream out_ready never reaches upstream combinationally.
    // Without it, a full register can still accept when it drains this cycle.
    generate
        if (SKID != 0) begin : gen_ready_skid
            assign bus.in_ready = !flush && !skid_valid;
        end else begin : gen_ready_comb
            assign bus.in_ready = !flush && (!main_valid || bus.out_ready);
        end
    endgenerate

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = main_valid && bus.out_ready;

    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = main_ctrl;

    // Next-state for both slots: flush empties everything, otherwise entries
    // move upstream -> (skid ->) main in order; invalid slots get zero ctrl.
    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        main_ctrl_nxt  = main_ctrl;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        skid_ctrl_nxt  = skid_ctrl;

        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (SKID == 0) begin
            if (in_fire) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = bus.in_data;
                main_ctrl_nxt  = bus.in_ctrl;
            end else if (out_fire) begin
                main_valid_nxt = 1'b0;
            end
        end else begin
            if (!main_valid || bus.out_ready) begin
                // Main is free this cycle; the older skid entry has priority.
                // in_ready is low whenever skid is full, so no input collides.
                if (skid_valid) begin
                    main_valid_nxt = 1'b1;
                    main_data_nxt  = skid_data;
                    main_ctrl_nxt  = skid_ctrl;
                    skid_valid_nxt = 1'b0;
                end else if (in_fire) begin
                    main_valid_nxt = 1'b1;
                    main_data_nxt  = bus.in_data;
                    main_ctrl_nxt  = bus.in_ctrl;
                end else begin
                    main_valid_nxt = 1'b0;
                end
            end else if (in_fire) begin
                // Main is stalled: park the accepted entry in the skid slot.
                skid_valid_nxt = 1'b1;
                skid_data_nxt  = bus.in_data;
                skid_ctrl_nxt  = bus.in_ctrl;
            end
        end

        // A bubble must never carry RegWrite/MemWrite downstream, whatever
        // path made the slot empty; the data payload is left alone.
        if (!main_valid_nxt) begin
            main_ctrl_nxt = '0;
        end
        if (!skid_valid_nxt) begin
            skid_ctrl_nxt = '0;
        end
    end

    // Main register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
            main_ctrl  <= main_ctrl_nxt;
        end
    end

    // Skid register state; stays empty forever when SKID=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else begin
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            skid_ctrl  <= skid_ctrl_nxt;
        end
    end

    // Stall counter: counts cycles the downstream refuses a valid entry,
    // sticks at all-ones, and survives flush so stalls stay visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives three stage registers side by side
// (SKID=0/CNT_W=16, SKID=1/CNT_W=16, SKID=1/CNT_W=4) and compares every
// output each cycle against a queue-level reference model of the stage.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int N  = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic clk = 1'b0;
    logic rst;

    logic          inValid  [N];
    logic [DW-1:0] inData   [N];
    logic [CW-1:0] inCtrl   [N];
    logic          outReady [N];
    logic          flushIn  [N];
    logic          inReady  [N];
    logic          outValid [N];
    logic [DW-1:0] outData  [N];
    logic [CW-1:0] outCtrl  [N];
    logic [15:0]   stallCnt [N];

    // Upstream source per DUT: entries waiting to be offered, in order.
    entry_t srcBuf [N][64];
    int     srcRd  [N];
    int     srcWr  [N];

    // Reference model: occupancy (0..2), entries in FIFO order, last data
    // shown on out_data, and the saturating stall count.
    entry_t hold   [N][2];
    int     held   [N];
    logic [DW-1:0] lastD [N];
    int     stallM [N];

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        localparam int SK  = (g == 0) ? 0 : 1;
        localparam int CNW = (g == 2) ? 4 : 16;
        logic [CNW-1:0] cnt;

        pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

        pipe_stage_reg #(
            .DATA_W(DW),
            .CTRL_W(CW),
            .SKID  (SK),
            .CNT_W (CNW)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .flush    (flushIn[g]),
            .bus      (bus),
            .stall_cnt(cnt)
        );

        assign bus.in_valid  = inValid[g];
        assign bus.in_data   = inData[g];
        assign bus.in_ctrl   = inCtrl[g];
        assign bus.out_ready = outReady[g];
        assign inReady[g]    = bus.in_ready;
        assign outValid[g]   = bus.out_valid;
        assign outData[g]    = bus.out_data;
        assign outCtrl[g]    = bus.out_ctrl;
        assign stallCnt[g]   = 16'(cnt);
    end

    function automatic bit isSkid(int i);
        return i != 0;
    endfunction

    function automatic int stallMax(int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    // Ready the stage should show given the model occupancy and this cycle's inputs.
    function automatic logic expReady(int i);
        if (flushIn[i]) return 1'b0;
        if (isSkid(i)) return held[i] < 2;
        return (held[i] == 0) || outReady[i];
    endfunction

    task automatic chk(string tag, int i, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d got %0h expected %0h", tag, i, got, exp);
        end
    endtask

    task automatic pushSrc(int i, logic [DW-1:0] d, logic [CW-1:0] c);
        entry_t e;
        e.d = d;
        e.c = c;
        srcBuf[i][srcWr[i] % 64] = e;
        srcWr[i]++;
    endtask

    task automatic resetModel();
        for (int i = 0; i < N; i++) begin
            held[i]    = 0;
            lastD[i]   = '0;
            stallM[i]  = 0;
            srcRd[i]   = srcWr[i];
            inValid[i] = 1'b0;
        end
    endtask

    // Present the head of the source (or junk with in_valid low) plus the
    // downstream ready and flush for this cycle.
    task automatic applyStimulus(int i, logic fl, logic ordy);
        entry_t e;
        flushIn[i]  = fl;
        outReady[i] = ordy;
        if (srcRd[i] != srcWr[i]) begin
            e          = srcBuf[i][srcRd[i] % 64];
            inValid[i] = 1'b1;
            inData[i]  = e.d;
            inCtrl[i]  = e.c;
        end else begin
            inValid[i] = 1'b0;
            inData[i]  = $urandom;
            inCtrl[i]  = CW'($urandom);
        end
    endtask

    task automatic checkOutput(int i);
        chk("in_ready",  i, 64'(inReady[i]),  64'(expReady(i)));
        chk("out_valid", i, 64'(outValid[i]), 64'(held[i] > 0));
        chk("out_ctrl",  i, 64'(outCtrl[i]),  (held[i] > 0) ? 64'(hold[i][0].c) : 64'(0));
        chk("out_data",  i, 64'(outData[i]),  (held[i] > 0) ? 64'(hold[i][0].d) : 64'(lastD[i]));
        chk("stall_cnt", i, 64'(stallCnt[i]), 64'(stallM[i]));
    endtask

    // Move the model across the coming rising edge using this cycle's inputs.
    task automatic advance(int i);
        bit     inFire;
        bit     outFire;
        entry_t e;
        inFire  = inValid[i] && expReady(i);
        outFire = (held[i] > 0) && outReady[i];
        if ((held[i] > 0) && !outReady[i] && (stallM[i] < stallMax(i))) stallM[i]++;
        if (flushIn[i]) begin
            held[i] = 0;
        end else begin
            if (outFire) begin
                hold[i][0] = hold[i][1];
                held[i]--;
            end
            if (inFire) begin
                e.d = inData[i];
                e.c = inCtrl[i];
                hold[i][held[i]] = e;
                held[i]++;
                srcRd[i]++;
            end
        end
        if (held[i] > 0) lastD[i] = hold[i][0].d;
    endtask

    task automatic applyCycle(logic [N-1:0] fl, logic [N-1:0] ordy);
        @(negedge clk);
        for (int i = 0; i < N; i++) applyStimulus(i, fl[i], ordy[i]);
        #1;
        for (int i = 0; i < N; i++) checkOutput(i);
        for (int i = 0; i < N; i++) advance(i);
    endtask

    task automatic pushAll(logic [DW-1:0] d, logic [CW-1:0] c);
        for (int i = 0; i < N; i++) pushSrc(i, d, c);
    endtask

    // Directed scenarios first, then a long randomized run, then reset mid-stall.
    initial begin
        logic [N-1:0] fl;
        logic [N-1:0] ordy;

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcRd[i]    = 0;
            srcWr[i]    = 0;
            flushIn[i]  = 1'b0;
            outReady[i] = 1'b0;
            inData[i]   = '0;
            inCtrl[i]   = '0;
        end
        resetModel();
        #12;
        for (int i = 0; i < N; i++) checkOutput(i);
        @(negedge clk);
        rst = 1'b0;

        // Streaming 1,2,3 with downstream always ready.
        pushAll(32'h1, 8'h11);
        pushAll(32'h2, 8'h22);
        pushAll(32'h3, 8'h33);
        for (int k = 0; k < 5; k++) applyCycle(3'b000, 3'b111);

        // Back-pressure A,B,C, then release.
        pushAll(32'hA, 8'h0A);
        pushAll(32'hB, 8'h0B);
        pushAll(32'hC, 8'h0C);
        for (int k = 0; k < 5; k++) applyCycle(3'b000, 3'b000);
        for (int k = 0; k < 5; k++) applyCycle(3'b000, 3'b111);
        chk("bp_stall", 1, 64'(stallCnt[1]), 64'(4));

        // Flush with ctrl=FF entries held in main (and skid).
        pushAll(32'hAAAA, 8'hFF);
        pushAll(32'hBBBB, 8'hFF);
        pushAll(32'hCCCC, 8'h5A);
        for (int k = 0; k < 3; k++) applyCycle(3'b000, 3'b000);
        applyCycle(3'b111, 3'b000);
        applyCycle(3'b000, 3'b000);
        chk("flush_data", 1, 64'(outData[1]), 64'(32'hAAAA));
        for (int k = 0; k < 5; k++) applyCycle(3'b000, 3'b111);

        // SKID=0 combinational ready: out_ready toggles with a continuous source.
        for (int k = 0; k < 8; k++) begin
            pushAll(32'h100 + DW'(k), CW'(k));
            applyCycle(3'b000, (k % 2 == 0) ? 3'b000 : 3'b111);
        end
        for (int k = 0; k < 6; k++) applyCycle(3'b000, 3'b111);

        // Saturation of the 4-bit counter.
        pushAll(32'hDEAD, 8'h77);
        for (int k = 0; k < 23; k++) applyCycle(3'b000, 3'b000);
        chk("sat15", 2, 64'(stallCnt[2]), 64'(15));
        for (int k = 0; k < 3; k++) applyCycle(3'b000, 3'b111);

        // Randomized traffic, stalls and occasional flushes.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if ((srcRd[i] == srcWr[i]) && ($urandom_range(0, 9) < 6))
                    pushSrc(i, $urandom, CW'($urandom));
                ordy[i] = ($urandom_range(0, 9) < 7);
                fl[i]   = ($urandom_range(0, 19) == 0);
            end
            applyCycle(fl, ordy);
        end

        // Reset asserted mid-cycle while stalled with valid entries.
        pushAll(32'hFACE, 8'hEE);
        pushAll(32'hBEEF, 8'hDD);
        for (int k = 0; k < 4; k++) applyCycle(3'b000, 3'b000);
        chk("pre_rst_valid", 1, 64'(outValid[1]), 64'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        resetModel();
        #1;
        for (int i = 0; i < N; i++) checkOutput(i);
        @(negedge clk);
        rst = 1'b0;
        pushAll(32'h5555, 8'h01);
        for (int k = 0; k < 3; k++) applyCycle(3'b000, 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register. It is the successor to the fixed-width inter-stage registers and is used between any two stages of the pipelined core (IF/ID, ID/EX, EX/MEM, MEM/WB).

Compared with the fixed-width registers, it adds:
- a separate data payload and control payload;
- valid/ready flow control (stall);
- synchronous flush, which inserts a bubble;
- guaranteed zeroing of control fields for bubbles;
- an optional one-entry skid buffer that removes the combinational ready path;
- a saturating stall-cycle counter.

## Interface
Parameters:
- DATA_W, 96: data payload width (e.g. ALU result, write data, PC+4). Never cleared by flush.
- CTRL_W, 8: control payload width (e.g. RegWrite, ResultSrc, MemWrite). Forced to 0 whenever the entry is not valid.
- SKID, 0: 0 means a single register with combinational in_ready; 1 means main register plus skid register, with registered in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous flush; kills all held entries and refuses input this cycle
- in_valid  in  1  upstream stage has a valid entry
- in_ready  out  1  this stage accepts the entry this cycle
- in_data  in  DATA_W  upstream data payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts the entry this cycle
- out_data  out  DATA_W  registered data payload
- out_ctrl  out  CTRL_W  registered control payload; 0 when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones

## Operation
Handshake rules:
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- The upstream stage must hold in_valid/in_data/in_ctrl stable until the input transfer completes.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush.

SKID=0:
- in_ready = !flush && (!out_valid || out_ready).
- On an input transfer, the main register loads in_data/in_ctrl and out_valid becomes 1.
- On an output transfer with no input transfer, out_valid becomes 0.

SKID=1:
- in_ready = !flush && !skid_valid, driven from flops only apart from the flush gate.
- Input transfer while main is empty, or while main is draining this cycle: the entry goes to main.
- Input transfer while main is valid and out_ready=0: the entry goes to skid, and skid_valid becomes 1.
- skid_valid=1 and out_ready=1: skid moves to main, skid_valid becomes 0, and in_ready returns to 1 the next cycle.

Flush (highest priority after reset):
- Next cycle: out_valid=0, skid_valid=0, out_ctrl=0.
- out_data holds its previous value.
- No input transfer occurs in the flush cycle.

Bubble rule:
- The out_ctrl flops are loaded with 0 whenever the resulting entry is invalid.
- A bubble therefore can never assert RegWrite or MemWrite downstream.

Stall counter:
- stall_cnt increments each cycle with out_valid && !out_ready.
- It holds at 2^CNT_W-1 (saturates).
- It is cleared only by rst; flush does not clear it.

## Timing
- Reset values (asserted asynchronously): out_valid=0, out_data=0, out_ctrl=0, skid_valid=0, stall_cnt=0, in_ready=1 (when flush=0).
- Latency: an entry accepted at edge N appears on out_* immediately after edge N, i.e. one cycle.
- Throughput: one entry per cycle in both modes while out_ready=1.
- SKID=1, main full and out_ready=0:
  - accepts exactly one more entry (into skid);
  - in_ready=0 from the next cycle until the first output transfer;
  - in_ready returns to 1 one cycle after that transfer.
- Simultaneous flush and in_valid: the input is not accepted (in_ready=0). Upstream sees no transfer.
- Simultaneous flush and out_ready: an output transfer still counts that cycle if out_valid=1. The register is empty next cycle.
- Reset mid-stall: all entries are discarded immediately and stall_cnt returns to 0. The first edge after rst deassertion can accept input.

## Test plan
- Reset/idle: assert rst mid-cycle while out_valid=1 → out_valid, out_ctrl, out_data and stall_cnt read 0 immediately; after release, in_ready=1.
- Streaming, both SKID values: send 0x1,0x2,0x3 on consecutive cycles with out_ready=1 → out_data shows 0x1,0x2,0x3 one cycle later each; out_valid stays high for exactly 3 cycles.
- Back-pressure, SKID=1: send A,B,C with out_ready=0 → A is held in main, B is held in skid, in_ready=0 so C is held. Raise out_ready → output order is A,B,C with none lost. stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush with ctrl bubble: in_ctrl=0xFF entry in main plus a skid entry, then assert flush for 1 cycle → next cycle out_valid=0 and out_ctrl=0x00 while out_data is unchanged; the in_valid entry presented during flush is accepted only after flush drops.
- SKID=0 combinational ready: out_valid=1 and out_ready toggles 0/1 → in_ready follows out_ready in the same cycle; a concurrent enqueue and dequeue keeps out_valid=1.
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15 and stays 15.
